// File: rtl/pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pkt_pkg
// Brief    : Shared beat tags, write-FSM states and stored-entry layout helpers
//            for the GMII packet packer.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package pkt_pkg;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_TAIL = 2'b10;
  localparam int         LEN_W    = 16;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_ACCUM = 2'd1,
    WR_DROP  = 2'd2
  } wr_state_t;

  function automatic int beat_bytes(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int vbytes_w(input int data_w);
    return $clog2(data_w / 8 + 1);
  endfunction

  // Stored entry is {trunc, len, vbytes, tag, data}.
  function automatic int entry_w(input int data_w);
    return 1 + LEN_W + vbytes_w(data_w) + 2 + data_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_commit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pkt_commit_fifo
// Brief    : Single-clock FIFO with speculative/commit write pointers and a
//            two-stage first-word-fall-through read path.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module pkt_commit_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rollback,
  input  logic                   commit,
  output logic                   full,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [$clog2(DEPTH):0] level
);

  localparam int             AW         = $clog2(DEPTH);
  localparam logic [AW:0]    c_DEPTH    = DEPTH[AW:0];
  localparam logic [AW:0]    c_PTR_ONE  = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_spec_ptr, r_commit_ptr, r_rd_ptr, r_pop_ptr;
  logic [WIDTH-1:0] r_stage;
  logic             r_stage_vld;
  logic             w_wr, w_avail, w_fetch, w_load_out;

  // Slots already fetched into the read stages count as free for writing.
  assign full       = (r_spec_ptr - r_rd_ptr) == c_DEPTH;
  assign w_wr       = wr_en && !full && !rollback;
  assign w_avail    = r_commit_ptr != r_rd_ptr;
  assign w_load_out = r_stage_vld && (!rd_valid || rd_ready);
  assign w_fetch    = w_avail && (!r_stage_vld || w_load_out);
  assign level      = r_commit_ptr - r_pop_ptr;

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_spec_ptr[AW-1:0]] <= wr_data;
    if (w_fetch)
      r_stage <= r_mem[r_rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spec_ptr   <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_pop_ptr    <= '0;
      r_stage_vld  <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
    end else begin
      if (rollback)
        r_spec_ptr <= r_commit_ptr;
      else if (w_wr)
        r_spec_ptr <= r_spec_ptr + c_PTR_ONE;

      if (commit)
        r_commit_ptr <= w_wr ? r_spec_ptr + c_PTR_ONE : r_spec_ptr;

      if (w_fetch) begin
        r_rd_ptr    <= r_rd_ptr + c_PTR_ONE;
        r_stage_vld <= 1'b1;
      end else if (w_load_out) begin
        r_stage_vld <= 1'b0;
      end

      if (w_load_out) begin
        rd_data  <= r_stage;
        rd_valid <= 1'b1;
      end else if (rd_ready) begin
        rd_valid <= 1'b0;
      end

      if (rd_valid && rd_ready)
        r_pop_ptr <= r_pop_ptr + c_PTR_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gmii_pkt_packer.sv
`default_nettype none
// ============================================================================
// Module   : gmii_pkt_packer
// Brief    : Packs a GMII byte stream into DATA_W-wide packet beats and stores
//            only complete, good packets in a commit/rollback FIFO.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module gmii_pkt_packer import pkt_pkg::*; #(
  parameter int DATA_W     = 128,
  parameter int FIFO_DEPTH = 512,
  parameter int MIN_LEN    = 17,
  parameter int MAX_LEN    = 2048,
  parameter int TRUNC_EN   = 1,
  parameter int CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  input  logic                          in_err,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_head,
  output logic                          out_tail,
  output logic [$clog2(DATA_W/8+1)-1:0] out_vbytes,
  output logic [15:0]                   out_len,
  output logic                          out_trunc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CNT_W-1:0]              cnt_pkt_ok,
  output logic [CNT_W-1:0]              cnt_drop_short,
  output logic [CNT_W-1:0]              cnt_drop_err,
  output logic [CNT_W-1:0]              cnt_drop_long,
  output logic [CNT_W-1:0]              cnt_drop_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int                c_BYTES     = beat_bytes(DATA_W);
  localparam int                c_VB_W      = vbytes_w(DATA_W);
  localparam int                c_LANE_W    = $clog2(c_BYTES);
  localparam int                c_ENT_W     = entry_w(DATA_W);
  localparam logic [c_LANE_W-1:0] c_LANE_LAST = c_LANE_W'(c_BYTES - 1);
  localparam logic [c_LANE_W-1:0] c_LANE_ONE  = c_LANE_W'(1);
  localparam logic [c_VB_W-1:0] c_VB_FULL   = c_VB_W'(c_BYTES);
  localparam logic [15:0]       c_MIN_LEN   = 16'(MIN_LEN);
  localparam logic [15:0]       c_MAX_LEN   = 16'(MAX_LEN);
  localparam bit                c_TRUNC     = (TRUNC_EN != 0);
  localparam logic [CNT_W-1:0]  c_CNT_ONE   = CNT_W'(1);

  wr_state_t             r_state, w_state_nx;
  logic [DATA_W-1:0]     r_beat;
  logic [15:0]           r_byte_cnt;
  logic [c_LANE_W-1:0]   r_lane;
  logic                  r_first, r_err, r_armed;

  logic w_wr_en, w_tail, w_trunc, w_rollback, w_commit, w_full;
  logic w_load_first, w_accept;
  logic w_inc_ok, w_inc_short, w_inc_err, w_inc_long, w_inc_full;
  logic [15:0]        w_len;
  logic [c_VB_W-1:0]  w_vb;
  logic [1:0]         w_tag, w_rd_tag;
  logic [c_ENT_W-1:0] w_wr_entry, w_rd_entry;

  // r_lane == byte_cnt mod BYTES, so lane 0 means the held beat is full.
  assign w_vb       = (r_lane == '0) ? c_VB_FULL : c_VB_W'(r_lane);
  assign w_len      = w_tail ? r_byte_cnt : 16'd0;
  assign w_tag      = (r_first ? TAG_HEAD : 2'b00) | (w_tail ? TAG_TAIL : 2'b00);
  assign w_wr_entry = {w_trunc, w_len, w_vb, w_tag, r_beat};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= WR_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx   = r_state;
    w_wr_en      = 1'b0;
    w_tail       = 1'b0;
    w_trunc      = 1'b0;
    w_rollback   = 1'b0;
    w_commit     = 1'b0;
    w_load_first = 1'b0;
    w_accept     = 1'b0;
    w_inc_ok     = 1'b0;
    w_inc_short  = 1'b0;
    w_inc_err    = 1'b0;
    w_inc_long   = 1'b0;
    w_inc_full   = 1'b0;
    unique case (r_state)
      WR_IDLE: begin
        if (in_valid && r_armed) begin
          w_load_first = 1'b1;
          w_state_nx   = WR_ACCUM;
        end
      end
      WR_ACCUM: begin
        if (!in_valid) begin
          w_state_nx = WR_IDLE;
          if (r_err) begin
            w_rollback = 1'b1;
            w_inc_err  = 1'b1;
          end else if (r_byte_cnt < c_MIN_LEN) begin
            w_rollback  = 1'b1;
            w_inc_short = 1'b1;
          end else begin
            w_wr_en = 1'b1;
            w_tail  = 1'b1;
            if (w_full) begin
              w_rollback = 1'b1;
              w_inc_full = 1'b1;
            end else begin
              w_commit = 1'b1;
              w_inc_ok = 1'b1;
            end
          end
        end else if (r_byte_cnt == c_MAX_LEN) begin
          // A byte beyond MAX_LEN: an earlier error still wins over truncation.
          w_state_nx = WR_DROP;
          if (r_err) begin
            w_rollback = 1'b1;
            w_inc_err  = 1'b1;
          end else if (!c_TRUNC) begin
            w_rollback = 1'b1;
            w_inc_long = 1'b1;
          end else begin
            w_wr_en = 1'b1;
            w_tail  = 1'b1;
            w_trunc = 1'b1;
            if (w_full) begin
              w_rollback = 1'b1;
              w_inc_full = 1'b1;
            end else begin
              w_commit = 1'b1;
              w_inc_ok = 1'b1;
            end
          end
        end else begin
          w_accept = 1'b1;
          if (r_lane == '0) begin
            w_wr_en = 1'b1;
            if (w_full) begin
              w_accept   = 1'b0;
              w_rollback = 1'b1;
              w_inc_full = 1'b1;
              w_state_nx = WR_DROP;
            end
          end
        end
      end
      WR_DROP: begin
        if (!in_valid) w_state_nx = WR_IDLE;
      end
      default: w_state_nx = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat     <= '0;
      r_byte_cnt <= '0;
      r_lane     <= '0;
      r_first    <= 1'b0;
      r_err      <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      if (!in_valid) r_armed <= 1'b1;
      if (w_load_first) begin
        r_beat     <= {in_data, {(DATA_W-8){1'b0}}};
        r_byte_cnt <= 16'd1;
        r_lane     <= c_LANE_ONE;
        r_first    <= 1'b1;
        r_err      <= in_err;
      end else if (w_accept) begin
        if (r_lane == '0) begin
          r_beat  <= {in_data, {(DATA_W-8){1'b0}}};
          r_first <= 1'b0;
        end else begin
          r_beat[DATA_W-1-8*int'(r_lane) -: 8] <= in_data;
        end
        r_byte_cnt <= r_byte_cnt + 16'd1;
        r_lane     <= (r_lane == c_LANE_LAST) ? '0 : r_lane + c_LANE_ONE;
        r_err      <= r_err | in_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_pkt_ok     <= '0;
      cnt_drop_short <= '0;
      cnt_drop_err   <= '0;
      cnt_drop_long  <= '0;
      cnt_drop_full  <= '0;
    end else begin
      if (w_inc_ok)    cnt_pkt_ok     <= cnt_pkt_ok     + c_CNT_ONE;
      if (w_inc_short) cnt_drop_short <= cnt_drop_short + c_CNT_ONE;
      if (w_inc_err)   cnt_drop_err   <= cnt_drop_err   + c_CNT_ONE;
      if (w_inc_long)  cnt_drop_long  <= cnt_drop_long  + c_CNT_ONE;
      if (w_inc_full)  cnt_drop_full  <= cnt_drop_full  + c_CNT_ONE;
    end
  end

  pkt_commit_fifo #(
    .WIDTH (c_ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (w_wr_en),
    .wr_data  (w_wr_entry),
    .rollback (w_rollback),
    .commit   (w_commit),
    .full     (w_full),
    .rd_data  (w_rd_entry),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .level    (fifo_level)
  );

  assign {out_trunc, out_len, out_vbytes, w_rd_tag, out_data} = w_rd_entry;
  assign out_head = (w_rd_tag & TAG_HEAD) != 2'b00;
  assign out_tail = (w_rd_tag & TAG_TAIL) != 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_gmii_pkt_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gmii_pkt_packer
// Brief    : Scoreboard bench: three packer instances (default, drop-on-long,
//            16-deep FIFO) fed from one GMII driver with per-instance gating.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gmii_pkt_packer;

  typedef struct packed {
    logic [127:0] data;
    logic         head;
    logic         tail;
    logic [4:0]   vb;
    logic [15:0]  len;
    logic         trunc;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_err = 1'b0;
  logic [2:0] sel = 3'b000;
  logic [2:0] vin;

  logic [127:0] o_data [3];
  logic         o_head [3], o_tail [3], o_trunc [3], o_valid [3];
  logic         rdy [3];
  logic [4:0]   o_vb [3];
  logic [15:0]  o_len [3];
  logic [31:0]  c_ok [3], c_short [3], c_err [3], c_long [3], c_full [3];
  logic [9:0]   lvl_a, lvl_b;
  logic [4:0]   lvl_c;

  int    total = 0;
  int    bad = 0;
  int    rmode [3];
  beat_t exp_q [3][$];
  beat_t held [3];
  bit    stall [3];

  always #5 clk = ~clk;
  assign vin = {3{in_valid}} & sel;

  gmii_pkt_packer u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(vin[0]), .in_err(in_err),
    .out_data(o_data[0]), .out_head(o_head[0]), .out_tail(o_tail[0]), .out_vbytes(o_vb[0]),
    .out_len(o_len[0]), .out_trunc(o_trunc[0]), .out_valid(o_valid[0]), .out_ready(rdy[0]),
    .cnt_pkt_ok(c_ok[0]), .cnt_drop_short(c_short[0]), .cnt_drop_err(c_err[0]),
    .cnt_drop_long(c_long[0]), .cnt_drop_full(c_full[0]), .fifo_level(lvl_a));

  gmii_pkt_packer #(.TRUNC_EN(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(vin[1]), .in_err(in_err),
    .out_data(o_data[1]), .out_head(o_head[1]), .out_tail(o_tail[1]), .out_vbytes(o_vb[1]),
    .out_len(o_len[1]), .out_trunc(o_trunc[1]), .out_valid(o_valid[1]), .out_ready(rdy[1]),
    .cnt_pkt_ok(c_ok[1]), .cnt_drop_short(c_short[1]), .cnt_drop_err(c_err[1]),
    .cnt_drop_long(c_long[1]), .cnt_drop_full(c_full[1]), .fifo_level(lvl_b));

  gmii_pkt_packer #(.FIFO_DEPTH(16)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(vin[2]), .in_err(in_err),
    .out_data(o_data[2]), .out_head(o_head[2]), .out_tail(o_tail[2]), .out_vbytes(o_vb[2]),
    .out_len(o_len[2]), .out_trunc(o_trunc[2]), .out_valid(o_valid[2]), .out_ready(rdy[2]),
    .cnt_pkt_ok(c_ok[2]), .cnt_drop_short(c_short[2]), .cnt_drop_err(c_err[2]),
    .cnt_drop_long(c_long[2]), .cnt_drop_full(c_full[2]), .fifo_level(lvl_c));

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic beat_t cur(input int k);
    beat_t b;
    b.data  = o_data[k];
    b.head  = o_head[k];
    b.tail  = o_tail[k];
    b.vb    = o_vb[k];
    b.len   = o_len[k];
    b.trunc = o_trunc[k];
    return b;
  endfunction

  // Expected beats for a frame whose byte i carries (i + seed).
  task automatic push_pkt(input int k, input int n, input int seed, input bit trunc);
    int nb;
    nb = (n + 15) / 16;
    for (int b = 0; b < nb; b++) begin
      beat_t e;
      e = '0;
      for (int j = 0; j < 16; j++)
        if (b * 16 + j < n) e.data[127-8*j -: 8] = 8'(b * 16 + j + seed);
      e.head  = (b == 0);
      e.tail  = (b == nb - 1);
      e.vb    = e.tail ? 5'(n - 16 * b) : 5'd16;
      e.len   = e.tail ? 16'(n) : 16'd0;
      e.trunc = e.tail && trunc;
      exp_q[k].push_back(e);
    end
  endtask

  task automatic send_frame(input int n, input int seed, input int err_at, input logic [2:0] s);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      sel      = s;
      in_valid = 1'b1;
      in_data  = 8'(i + seed);
      in_err   = (i == err_at);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_err   = 1'b0;
  endtask

  task automatic wait_drain(input int k, input int budget);
    int c;
    c = 0;
    while (exp_q[k].size() != 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    chk($sformatf("drain_dut%0d_left", k), 160'(exp_q[k].size()), 160'd0);
    exp_q[k].delete();
    repeat (8) @(posedge clk);
  endtask

  task automatic mon_one(input int k);
    beat_t a, e;
    a = cur(k);
    if (!rst_n) begin
      stall[k] = 1'b0;
    end else begin
      if (stall[k]) begin
        chk($sformatf("stall_valid_dut%0d", k), 160'(o_valid[k]), 160'd1);
        chk($sformatf("stall_hold_dut%0d", k), 160'(a), 160'(held[k]));
      end
      if (o_valid[k] && rdy[k]) begin
        if (exp_q[k].size() == 0) begin
          chk($sformatf("extra_beat_dut%0d", k), 160'(a), 160'd0);
          if (a == '0) begin
            bad++;
            $display("FAIL extra_beat_dut%0d: got zero beat expected none", k);
          end
        end else begin
          e = exp_q[k].pop_front();
          chk($sformatf("beat_dut%0d", k), 160'(a), 160'(e));
        end
      end
      stall[k] = o_valid[k] && !rdy[k];
      held[k]  = a;
    end
  endtask

  always @(negedge clk)
    for (int k = 0; k < 3; k++) mon_one(k);

  initial begin
    for (int k = 0; k < 3; k++) rdy[k] = 1'b0;
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++)
        rdy[k] = (rmode[k] == 2) ? ~rdy[k] : (rmode[k] == 1);
    end
  end

  initial begin
    beat_t e;
    rmode[0] = 1; rmode[1] = 1; rmode[2] = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_valid", 160'(o_valid[0]), 160'd0);
    chk("reset_data", 160'(o_data[0]), 160'd0);
    chk("reset_ok", 160'(c_ok[0]), 160'd0);
    chk("reset_level", 160'(lvl_a), 160'd0);

    // 64-byte frame: four full beats, tail len 64
    push_pkt(0, 64, 0, 1'b0);
    send_frame(64, 0, -1, 3'b001);
    wait_drain(0, 200);
    chk("a_ok_64", 160'(c_ok[0]), 160'd1);

    // 17-byte frame, expected beats written out by hand
    e = '0;
    e.data = 128'h000102030405060708090a0b0c0d0e0f; e.head = 1'b1; e.vb = 5'd16;
    exp_q[0].push_back(e);
    e = '0;
    e.data = {8'h10, 120'h0}; e.tail = 1'b1; e.vb = 5'd1; e.len = 16'd17;
    exp_q[0].push_back(e);
    send_frame(17, 0, -1, 3'b001);
    wait_drain(0, 200);
    chk("a_ok_17", 160'(c_ok[0]), 160'd2);

    send_frame(16, 0, -1, 3'b001);
    repeat (10) @(posedge clk);
    chk("a_short", 160'(c_short[0]), 160'd1);

    send_frame(100, 0, 50, 3'b001);
    repeat (10) @(posedge clk);
    chk("a_err", 160'(c_err[0]), 160'd1);
    chk("a_ok_after_drops", 160'(c_ok[0]), 160'd2);

    // 3000-byte frame into both trunc and drop variants
    push_pkt(0, 2048, 0, 1'b1);
    send_frame(3000, 0, -1, 3'b011);
    wait_drain(0, 3000);
    chk("a_ok_trunc", 160'(c_ok[0]), 160'd3);
    chk("a_long", 160'(c_long[0]), 160'd0);
    chk("b_long", 160'(c_long[1]), 160'd1);
    chk("b_ok", 160'(c_ok[1]), 160'd0);
    chk("b_level", 160'(lvl_b), 160'd0);

    // 16-deep FIFO held stalled: second 200-byte frame must overflow
    push_pkt(2, 200, 5, 1'b0);
    send_frame(200, 5, -1, 3'b100);
    repeat (10) @(posedge clk);
    chk("c_level_13", 160'(lvl_c), 160'd13);
    chk("c_valid_stalled", 160'(o_valid[2]), 160'd1);
    send_frame(200, 9, -1, 3'b100);
    repeat (10) @(posedge clk);
    chk("c_full", 160'(c_full[2]), 160'd1);
    chk("c_ok", 160'(c_ok[2]), 160'd1);
    chk("c_level_kept", 160'(lvl_c), 160'd13);
    rmode[2] = 1;
    wait_drain(2, 200);
    chk("c_level_empty", 160'(lvl_c), 160'd0);

    // back-to-back frames with toggling ready
    rmode[0] = 2;
    push_pkt(0, 70, 8'h40, 1'b0);
    push_pkt(0, 45, 8'h80, 1'b0);
    send_frame(70, 8'h40, -1, 3'b001);
    send_frame(45, 8'h80, -1, 3'b001);
    wait_drain(0, 500);
    chk("a_ok_b2b", 160'(c_ok[0]), 160'd5);
    rmode[0] = 1;

    // reset mid-frame, keep in_valid high across release
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      sel = 3'b001; in_valid = 1'b1; in_data = 8'(i + 8'h20);
    end
    @(posedge clk); #1 rst_n = 1'b0;
    #2;
    chk("rst_mid_valid", 160'(o_valid[0]), 160'd0);
    chk("rst_mid_ok", 160'(c_ok[0]), 160'd0);
    chk("rst_mid_short", 160'(c_short[0]), 160'd0);
    chk("rst_mid_c_full", 160'(c_full[2]), 160'd0);
    chk("rst_mid_level", 160'(lvl_a), 160'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    chk("armed_short", 160'(c_short[0]), 160'd0);
    chk("armed_ok", 160'(c_ok[0]), 160'd0);
    push_pkt(0, 20, 8'h11, 1'b0);
    send_frame(20, 8'h11, -1, 3'b001);
    wait_drain(0, 200);
    chk("post_rst_ok", 160'(c_ok[0]), 160'd1);
    chk("post_rst_level", 160'(lvl_a), 160'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
